// File: rtl/bdt_rom_csr.sv
// Boot Device Table ROM on the CSR bus: a parameter-built word image behind a
// two-stage read pipeline (request capture, then word select and response).
module bdt_rom_csr #(
    parameter logic [31:0] BASE_ADDR             = 32'h0000_3000,
    parameter int unsigned ENTRY_COUNT           = 1,
    parameter int unsigned IRQ_ROUTE_TABLE_COUNT = 1,
    parameter logic [15:0] CLASS_ID                [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [15:0] SUBCLASS_ID             [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [15:0] INSTANCE_ID             [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [15:0] DEVICE_VERSION          [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [31:0] CAPS0                   [ENTRY_COUNT] = '{default: 32'h0},
    parameter logic [31:0] CAPS1                   [ENTRY_COUNT] = '{default: 32'h0},
    parameter logic [15:0] IRQ_ROUTE_OFFSET        [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [15:0] IRQ_ROUTE_COUNT_PER_DEV [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [63:0] MMIO_BASE               [ENTRY_COUNT] = '{default: 64'h0},
    parameter logic [31:0] MMIO_SIZE               [ENTRY_COUNT] = '{default: 32'h0},
    parameter logic [31:0] IO_PORT_BASE            [ENTRY_COUNT] = '{default: 32'h0},
    parameter logic [15:0] IO_PORT_SIZE            [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [15:0] BLOCK_SECTOR_SIZE       [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [15:0] CAI_QUEUE_COUNT         [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [15:0] CAI_DOORBELL_OFFSET     [ENTRY_COUNT] = '{default: 16'h0},
    parameter logic [15:0] IRQ_ROUTE_DOMAIN_ID [(IRQ_ROUTE_TABLE_COUNT > 0) ? IRQ_ROUTE_TABLE_COUNT : 1] = '{default: 16'h0},
    parameter logic [15:0] IRQ_ROUTE_LINE      [(IRQ_ROUTE_TABLE_COUNT > 0) ? IRQ_ROUTE_TABLE_COUNT : 1] = '{default: 16'h0},
    parameter logic [15:0] IRQ_ROUTE_FLAGS     [(IRQ_ROUTE_TABLE_COUNT > 0) ? IRQ_ROUTE_TABLE_COUNT : 1] = '{default: 16'h0}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_req_valid,
    output logic        csr_req_ready,
    input  logic [31:0] csr_req_addr,
    input  logic        csr_req_write,
    input  logic [31:0] csr_req_wdata,
    input  logic [1:0]  csr_req_priv,
    output logic        csr_rsp_valid,
    output logic [31:0] csr_rsp_rdata,
    output logic        csr_rsp_fault
);

    localparam int unsigned HDR_BYTES     = 32;
    localparam int unsigned ENT_BYTES     = 48;
    localparam int unsigned RTE_BYTES     = 8;
    localparam int unsigned RTE_TABLE_OFF = HDR_BYTES + ENTRY_COUNT * ENT_BYTES;
    localparam int unsigned TOTAL_BYTES   = RTE_TABLE_OFF + IRQ_ROUTE_TABLE_COUNT * RTE_BYTES;
    localparam logic [31:0] TOTAL         = 32'(TOTAL_BYTES);
    localparam logic [31:0] WINDOW_BYTES  = 32'h0000_1000;
    localparam int unsigned ROM_WORDS     = TOTAL_BYTES / 4;
    localparam int unsigned IDX_W         = $clog2(ROM_WORDS);
    localparam int unsigned ROM_DEPTH     = 32'd1 << IDX_W;

    // Word image padded to a power-of-two depth so any index is in range.
    logic [31:0] rom_s [ROM_DEPTH];

    assign rom_s[0] = 32'h5444_4243;
    assign rom_s[1] = {16'(HDR_BYTES), 16'h0001};
    assign rom_s[2] = {16'(ENTRY_COUNT), 16'(ENT_BYTES)};
    assign rom_s[3] = TOTAL;
    assign rom_s[4] = 32'(RTE_TABLE_OFF);
    assign rom_s[5] = 32'(IRQ_ROUTE_TABLE_COUNT);
    assign rom_s[6] = 32'h0000_0000;
    assign rom_s[7] = 32'h0000_0000;

    for (genvar i = 0; i < ENTRY_COUNT; i++) begin : g_ent
        localparam int unsigned B = (HDR_BYTES + i * ENT_BYTES) / 4;
        assign rom_s[B + 0]  = {16'(ENT_BYTES), 16'h0001};
        assign rom_s[B + 1]  = {SUBCLASS_ID[i], CLASS_ID[i]};
        assign rom_s[B + 2]  = {DEVICE_VERSION[i], INSTANCE_ID[i]};
        assign rom_s[B + 3]  = CAPS0[i];
        assign rom_s[B + 4]  = CAPS1[i];
        assign rom_s[B + 5]  = {IRQ_ROUTE_COUNT_PER_DEV[i], IRQ_ROUTE_OFFSET[i]};
        assign rom_s[B + 6]  = MMIO_BASE[i][31:0];
        assign rom_s[B + 7]  = MMIO_BASE[i][63:32];
        assign rom_s[B + 8]  = MMIO_SIZE[i];
        assign rom_s[B + 9]  = IO_PORT_BASE[i];
        assign rom_s[B + 10] = {BLOCK_SECTOR_SIZE[i], IO_PORT_SIZE[i]};
        assign rom_s[B + 11] = {CAI_DOORBELL_OFFSET[i], CAI_QUEUE_COUNT[i]};
    end

    for (genvar j = 0; j < IRQ_ROUTE_TABLE_COUNT; j++) begin : g_rte
        localparam int unsigned B = (RTE_TABLE_OFF + j * RTE_BYTES) / 4;
        assign rom_s[B + 0] = {IRQ_ROUTE_LINE[j], IRQ_ROUTE_DOMAIN_ID[j]};
        assign rom_s[B + 1] = {16'h0000, IRQ_ROUTE_FLAGS[j]};
    end

    for (genvar k = ROM_WORDS; k < ROM_DEPTH; k++) begin : g_pad
        assign rom_s[k] = 32'h0000_0000;
    end

    logic             req_valid_d, req_valid_q;
    logic             req_fault_d, req_fault_q;
    logic [IDX_W-1:0] req_idx_d,   req_idx_q;
    logic             rsp_valid_d, rsp_valid_q;
    logic [31:0]      rsp_rdata_d, rsp_rdata_q;
    logic             rsp_fault_d, rsp_fault_q;
    logic [31:0]      off_s;
    logic             fault_s;
    logic             unused_s;

    assign unused_s = ^{csr_req_wdata, csr_req_priv};

    // Request decode: classify the access and reduce a good address to a word index.
    always_comb begin
        off_s   = csr_req_addr - BASE_ADDR;
        fault_s = csr_req_write
                | (csr_req_addr[1:0] != 2'b00)
                | (off_s >= WINDOW_BYTES)
                | (off_s >= TOTAL);
        req_valid_d = csr_req_valid;
        req_fault_d = fault_s;
        if (fault_s) begin
            req_idx_d = '0;
        end else begin
            req_idx_d = off_s[IDX_W+1:2];
        end
    end

    // Response build: faulted or idle slots carry zero data.
    always_comb begin
        rsp_valid_d = req_valid_q;
        if (req_valid_q && !req_fault_q) begin
            rsp_rdata_d = rom_s[req_idx_q];
            rsp_fault_d = 1'b0;
        end else if (req_valid_q) begin
            rsp_rdata_d = 32'h0000_0000;
            rsp_fault_d = 1'b1;
        end else begin
            rsp_rdata_d = 32'h0000_0000;
            rsp_fault_d = 1'b0;
        end
    end

    // Pipeline registers; reset discards any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid_q <= 1'b0;
            req_fault_q <= 1'b0;
            req_idx_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_fault_q <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            req_fault_q <= req_fault_d;
            req_idx_q   <= req_idx_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign csr_req_ready = 1'b1;
    assign csr_rsp_valid = rsp_valid_q;
    assign csr_rsp_rdata = rsp_rdata_q;
    assign csr_rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_bdt_rom_csr.sv
// Bench for bdt_rom_csr: directed reads from the table layout, random reads
// against a field-level model, pipeline timing and asynchronous reset.
module tb_bdt_rom_csr;

    localparam logic [31:0] BASE        = 32'h0000_3000;
    localparam int          NE          = 1;
    localparam int          NR          = 1;
    localparam logic [15:0] P_CLASS     = 16'h0001;
    localparam logic [15:0] P_SUB       = 16'h0000;
    localparam logic [15:0] P_INST      = 16'h0000;
    localparam logic [15:0] P_DVER      = 16'h0001;
    localparam logic [31:0] P_CAPS0     = 32'h0000_0001;
    localparam logic [31:0] P_CAPS1     = 32'hA5A5_0F0F;
    localparam logic [15:0] P_IROFF     = 16'd80;
    localparam logic [15:0] P_IRCNT     = 16'd1;
    localparam logic [63:0] P_MMIO_BASE = 64'h1234_5678_9ABC_DEF0;
    localparam logic [31:0] P_MMIO_SIZE = 32'h0000_1000;
    localparam logic [31:0] P_IO_BASE   = 32'h0000_00F0;
    localparam logic [15:0] P_IO_SIZE   = 16'd8;
    localparam logic [15:0] P_SECTOR    = 16'd512;
    localparam logic [15:0] P_QCNT      = 16'h0000;
    localparam logic [15:0] P_DB        = 16'h0000;
    localparam logic [15:0] P_RDOM      = 16'h0000;
    localparam logic [15:0] P_RLINE     = 16'd5;
    localparam logic [15:0] P_RFLAGS    = 16'h0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_req_valid;
    logic        csr_req_ready;
    logic [31:0] csr_req_addr;
    logic        csr_req_write;
    logic [31:0] csr_req_wdata;
    logic [1:0]  csr_req_priv;
    logic        csr_rsp_valid;
    logic [31:0] csr_rsp_rdata;
    logic        csr_rsp_fault;

    int n_vec = 0;
    int n_err = 0;

    bit          q_v = 1'b0;
    logic [31:0] q_a = 32'h0;
    logic [31:0] q_d = 32'h0;
    bit          q_f = 1'b0;

    always #5 clk = ~clk;

    bdt_rom_csr #(
        .BASE_ADDR(BASE), .ENTRY_COUNT(NE), .IRQ_ROUTE_TABLE_COUNT(NR),
        .CLASS_ID('{P_CLASS}), .SUBCLASS_ID('{P_SUB}), .INSTANCE_ID('{P_INST}),
        .DEVICE_VERSION('{P_DVER}), .CAPS0('{P_CAPS0}), .CAPS1('{P_CAPS1}),
        .IRQ_ROUTE_OFFSET('{P_IROFF}), .IRQ_ROUTE_COUNT_PER_DEV('{P_IRCNT}),
        .MMIO_BASE('{P_MMIO_BASE}), .MMIO_SIZE('{P_MMIO_SIZE}),
        .IO_PORT_BASE('{P_IO_BASE}), .IO_PORT_SIZE('{P_IO_SIZE}),
        .BLOCK_SECTOR_SIZE('{P_SECTOR}), .CAI_QUEUE_COUNT('{P_QCNT}),
        .CAI_DOORBELL_OFFSET('{P_DB}), .IRQ_ROUTE_DOMAIN_ID('{P_RDOM}),
        .IRQ_ROUTE_LINE('{P_RLINE}), .IRQ_ROUTE_FLAGS('{P_RFLAGS})
    ) dut (
        .clk(clk), .rst(rst),
        .csr_req_valid(csr_req_valid), .csr_req_ready(csr_req_ready),
        .csr_req_addr(csr_req_addr), .csr_req_write(csr_req_write),
        .csr_req_wdata(csr_req_wdata), .csr_req_priv(csr_req_priv),
        .csr_rsp_valid(csr_rsp_valid), .csr_rsp_rdata(csr_rsp_rdata),
        .csr_rsp_fault(csr_rsp_fault)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Field-level model: locate header / entry / route by byte offset.
    function automatic void ref_read(input logic [31:0] a, input bit w,
                                     output logic [31:0] d, output bit f);
        int          off, total, rt_off, fo, ro;
        logic [31:0] hw [8];
        logic [31:0] ew [12];
        logic [31:0] rw [2];
        logic [63:0] mb;
        total  = 32 + NE * 48 + NR * 8;
        rt_off = 32 + NE * 48;
        d = 32'h0;
        f = 1'b1;
        if (w || a[1:0] != 2'b00 || a < BASE || (a - BASE) >= 32'd4096) return;
        off = int'(a - BASE);
        if (off >= total) return;
        f  = 1'b0;
        mb = P_MMIO_BASE;
        hw = '{32'h5444_4243, {16'd32, 16'd1}, {16'(NE), 16'd48}, 32'(total),
               32'(rt_off), 32'(NR), 32'h0, 32'h0};
        ew = '{{16'd48, 16'd1}, {P_SUB, P_CLASS}, {P_DVER, P_INST}, P_CAPS0, P_CAPS1,
               {P_IRCNT, P_IROFF}, mb[31:0], mb[63:32], P_MMIO_SIZE, P_IO_BASE,
               {P_SECTOR, P_IO_SIZE}, {P_DB, P_QCNT}};
        rw = '{{P_RLINE, P_RDOM}, {16'h0, P_RFLAGS}};
        if (off < 32) begin
            d = hw[off / 4];
        end else if (off < rt_off) begin
            fo = (off - 32) % 48;
            d  = ew[fo / 4];
        end else begin
            ro = (off - rt_off) % 8;
            d  = rw[ro / 4];
        end
    endfunction

    // One clock: drive a request, then check the response due from the previous edge.
    task automatic cycle(input bit v, input logic [31:0] a, input bit w,
                         input logic [31:0] ed, input bit ef);
        csr_req_valid = v;
        csr_req_addr  = a;
        csr_req_write = w;
        csr_req_wdata = $urandom;
        csr_req_priv  = 2'($urandom_range(0, 3));
        @(posedge clk);
        #1;
        check_eq("rsp_valid", 32'(csr_rsp_valid), 32'(q_v));
        if (q_v) begin
            check_eq($sformatf("rdata@%h", q_a), csr_rsp_rdata, q_d);
            check_eq($sformatf("fault@%h", q_a), 32'(csr_rsp_fault), 32'(q_f));
        end
        q_v = v; q_a = a; q_d = ed; q_f = ef;
    endtask

    typedef struct { logic [31:0] a; bit w; logic [31:0] d; bit f; } vec_t;
    vec_t dir_v [17] = '{
        '{32'h3000, 1'b0, 32'h5444_4243, 1'b0}, '{32'h3004, 1'b0, 32'h0020_0001, 1'b0},
        '{32'h3008, 1'b0, 32'h0001_0030, 1'b0}, '{32'h300C, 1'b0, 32'h0000_0058, 1'b0},
        '{32'h3020, 1'b0, 32'h0030_0001, 1'b0}, '{32'h3024, 1'b0, 32'h0000_0001, 1'b0},
        '{32'h3028, 1'b0, 32'h0001_0000, 1'b0}, '{32'h302C, 1'b0, 32'h0000_0001, 1'b0},
        '{32'h3034, 1'b0, 32'h0001_0050, 1'b0}, '{32'h3048, 1'b0, 32'h0200_0008, 1'b0},
        '{32'h304C, 1'b0, 32'h0000_0000, 1'b0}, '{32'h3050, 1'b0, 32'h0005_0000, 1'b0},
        '{32'h3054, 1'b0, 32'h0000_0000, 1'b0}, '{32'h3058, 1'b0, 32'h0000_0000, 1'b1},
        '{32'h3002, 1'b0, 32'h0000_0000, 1'b1}, '{32'h4000, 1'b0, 32'h0000_0000, 1'b1},
        '{32'h3000, 1'b1, 32'h0000_0000, 1'b1}
    };

    initial begin
        logic [31:0] a, ed;
        bit          w, ef;
        rst = 1'b1;
        csr_req_valid = 1'b0; csr_req_addr = 32'h0; csr_req_write = 1'b0;
        csr_req_wdata = 32'h0; csr_req_priv = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_valid", 32'(csr_rsp_valid), 32'h0);
        check_eq("reset_rdata", csr_rsp_rdata, 32'h0);
        check_eq("reset_fault", 32'(csr_rsp_fault), 32'h0);
        check_eq("req_ready", 32'(csr_req_ready), 32'h1);
        rst = 1'b0;
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Directed table, issued back to back.
        foreach (dir_v[i]) cycle(1'b1, dir_v[i].a, dir_v[i].w, dir_v[i].d, dir_v[i].f);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Isolated request: nothing after edge N, response after edge N+1.
        cycle(1'b1, 32'h300C, 1'b0, 32'h0000_0058, 1'b0);
        repeat (3) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Randomized reads against the model.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'h4000 + 32'($urandom_range(0, 15) * 4);
                1:       a = 32'h2FFC;
                default: a = 32'h3000 + 32'($urandom_range(0, 25) * 4);
            endcase
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            w = ($urandom_range(0, 7) == 0);
            ref_read(a, w, ed, ef);
            cycle($urandom_range(0, 3) != 0, a, w, ed, ef);
        end
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // Asynchronous reset while a response is showing and another is pending.
        cycle(1'b1, 32'h3000, 1'b0, 32'h5444_4243, 1'b0);
        cycle(1'b1, 32'h3004, 1'b0, 32'h0020_0001, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_valid", 32'(csr_rsp_valid), 32'h0);
        check_eq("rst_async_rdata", csr_rsp_rdata, 32'h0);
        check_eq("rst_async_fault", 32'(csr_rsp_fault), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_v = 1'b0;
        csr_req_valid = 1'b0;
        repeat (4) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
